// File: rtl/bcd_seg_pkg.sv
// Shared scan-state encoding and active-low 7-segment patterns (bit order g..a)
// for the bcd_seg_scan display stage.
package bcd_seg_pkg;

   typedef enum logic [1:0] {
      UNITS_ON = 2'd0,
      GAP0     = 2'd1,
      TENS_ON  = 2'd2,
      GAP1     = 2'd3
   } scan_state_t;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [1:0] AN_OFF   = 2'b11;
   localparam logic [1:0] AN_UNITS = 2'b10;
   localparam logic [1:0] AN_TENS  = 2'b01;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; codes 10..15 show a dash.
module bcd_to_seg7
   import bcd_seg_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_seg_scan.sv
// Two-digit multiplexed common-anode display with a one-deep pending buffer
// committed at frame start. Optional macro: LEADING_ZERO_BLANK_EN.
module bcd_seg_scan
   import bcd_seg_pkg::*;
#(
   parameter int ON_CYCLES  = 50000,
   parameter int GAP_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [3:0] in_tens,
   input  logic [3:0] in_units,
   input  logic       in_cout,
   output logic       in_ready,
   output logic [6:0] seg_n,
   output logic       dp_n,
   output logic [1:0] an_n,
   output logic       err
);

   localparam int MAX_LEN = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
   localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

   scan_state_t   state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic          last;

   logic [3:0] pend_tens, pend_units;
   logic       pend_cout, full, full_next;
   logic [3:0] com_tens, com_units, com_tens_next, com_units_next;
   logic       com_cout, com_cout_next;
   logic       accept, commit, blank_tens;

   logic [3:0] dec_in;
   logic [6:0] dec_seg;
   logic [6:0] seg_d;
   logic [1:0] an_d;
   logic       dp_d, err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= GAP1;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      last       = (state == UNITS_ON || state == TENS_ON) ? (cnt == ON_LAST)
                                                           : (cnt == GAP_LAST);
      cnt_next   = last ? '0 : cnt + 1'b1;
      if (last) begin
         case (state)
            UNITS_ON: state_next = GAP0;
            GAP0:     state_next = TENS_ON;
            TENS_ON:  state_next = GAP1;
            default:  state_next = UNITS_ON;
         endcase
      end
   end

   // Pending is only swapped into the committed set at the frame boundary.
   always_comb begin
      accept         = in_valid && in_ready;
      commit         = full && (state == GAP1) && (state_next == UNITS_ON);
      full_next      = commit ? 1'b0 : (accept ? 1'b1 : full);
      com_tens_next  = commit ? pend_tens  : com_tens;
      com_units_next = commit ? pend_units : com_units;
      com_cout_next  = commit ? pend_cout  : com_cout;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_tens  <= '0;
         pend_units <= '0;
         pend_cout  <= 1'b0;
         full       <= 1'b0;
         com_tens   <= '0;
         com_units  <= '0;
         com_cout   <= 1'b0;
      end else begin
         if (accept) begin
            pend_tens  <= in_tens;
            pend_units <= in_units;
            pend_cout  <= in_cout;
         end
         full      <= full_next;
         com_tens  <= com_tens_next;
         com_units <= com_units_next;
         com_cout  <= com_cout_next;
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   assign blank_tens = (com_tens_next == 4'd0) && !com_cout_next;
`else
   assign blank_tens = 1'b0;
`endif

   assign dec_in = (state_next == TENS_ON) ? com_tens_next : com_units_next;

   bcd_to_seg7 u_dec (
      .bcd (dec_in),
      .seg (dec_seg)
   );

   // Outputs are decoded from the upcoming state so they switch with it.
   always_comb begin
      seg_d = SEG_BLANK;
      an_d  = AN_OFF;
      dp_d  = 1'b1;
      err_d = (com_tens_next > 4'd9) || (com_units_next > 4'd9);
      case (state_next)
         UNITS_ON: begin
            seg_d = dec_seg;
            an_d  = AN_UNITS;
         end
         TENS_ON: begin
            if (!blank_tens) begin
               seg_d = dec_seg;
               an_d  = AN_TENS;
               dp_d  = ~com_cout_next;
            end
         end
         default: begin
            seg_d = SEG_BLANK;
            an_d  = AN_OFF;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_n    <= SEG_BLANK;
         an_n     <= AN_OFF;
         dp_n     <= 1'b1;
         err      <= 1'b0;
         in_ready <= 1'b1;
      end else begin
         seg_n    <= seg_d;
         an_n     <= an_d;
         dp_n     <= dp_d;
         err      <= err_d;
         in_ready <= ~full_next;
      end
   end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Self-checking bench for bcd_seg_scan (ON=4, GAP=2): frame-position reference
// model checked every cycle, plus table-driven and directed corner cases.
module tb_bcd_seg_scan;

   localparam int ON  = 4;
   localparam int GAP = 2;
   localparam int FR  = 2 * (ON + GAP);

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] in_tens, in_units;
   logic       in_cout;
   logic       in_ready;
   logic [6:0] seg_n;
   logic       dp_n;
   logic [1:0] an_n;
   logic       err;

   int checks = 0;
   int passes = 0;

   bcd_seg_scan #(.ON_CYCLES(ON), .GAP_CYCLES(GAP)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_tens  (in_tens),
      .in_units (in_units),
      .in_cout  (in_cout),
      .in_ready (in_ready),
      .seg_n    (seg_n),
      .dp_n     (dp_n),
      .an_n     (an_n),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: edges since reset release decide the frame position.
   int         n;
   logic [3:0] m_pt, m_pu, m_ct, m_cu;
   logic       m_pc, m_cc, m_full, m_acc;
   logic [6:0] seg_tab [10];

   typedef struct {
      logic [3:0] tens;
      logic [3:0] units;
      logic       cout;
      logic [6:0] exp_useg;
      logic [1:0] exp_tan;
      logic [6:0] exp_tseg;
      logic       exp_dp;
      logic       exp_err;
   } vec_t;

   vec_t vecs [7];

   function automatic logic [6:0] refDecode(input logic [3:0] d);
      return (d > 4'd9) ? 7'h3F : seg_tab[d];
   endfunction

   // 0 = units lit, 1 = gap after units, 2 = tens lit, 3 = gap after tens
   function automatic int phaseOf(input int edges);
      int q;
      if (edges < GAP) return 3;
      q = (edges - GAP) % FR;
      if (q < ON) return 0;
      if (q < ON + GAP) return 1;
      if (q < 2 * ON + GAP) return 2;
      return 3;
   endfunction

   function automatic logic [11:0] expOut();
      logic [6:0] s;
      logic [1:0] a;
      logic       d, e;
      s = 7'h7F;
      a = 2'b11;
      d = 1'b1;
      e = (m_ct > 4'd9) || (m_cu > 4'd9);
      if (phaseOf(n) == 0) begin
         s = refDecode(m_cu);
         a = 2'b10;
      end else if (phaseOf(n) == 2) begin
`ifdef LEADING_ZERO_BLANK_EN
         if (!(m_ct == 4'd0 && !m_cc)) begin
`else
         begin
`endif
            s = refDecode(m_ct);
            a = 2'b01;
            d = ~m_cc;
         end
      end
      return {~m_full, s, d, a, e};
   endfunction

   task automatic modelReset();
      n = 0;
      m_full = 1'b0;
      m_acc = 1'b0;
      m_pt = '0; m_pu = '0; m_pc = 1'b0;
      m_ct = '0; m_cu = '0; m_cc = 1'b0;
   endtask

   task automatic modelStep();
      if (!rst_n) begin
         modelReset();
      end else begin
         n++;
         m_acc = in_valid && !m_full;
         if (m_full && n >= GAP && ((n - GAP) % FR) == 0) begin
            m_ct = m_pt; m_cu = m_pu; m_cc = m_pc;
            m_full = 1'b0;
         end
         if (m_acc) begin
            m_pt = in_tens; m_pu = in_units; m_pc = in_cout;
            m_full = 1'b1;
         end
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic applyStimulus(input logic v, input logic [3:0] t, input logic [3:0] u, input logic c);
      in_valid = v;
      in_tens  = t;
      in_units = u;
      in_cout  = c;
   endtask

   task automatic tick();
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkOutput("cycle{ready,seg,dp,an,err}", {20'd0, in_ready, seg_n, dp_n, an_n, err},
                  {20'd0, expOut()});
   endtask

   task automatic sendValue(input logic [3:0] t, input logic [3:0] u, input logic c);
      bit done = 0;
      applyStimulus(1'b1, t, u, c);
      for (int i = 0; i < 40 && !done; i++) begin
         tick();
         if (m_acc) done = 1;
      end
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);
      checkOutput("send_accepted", {31'd0, done}, 32'd1);
   endtask

   task automatic waitCommit();
      bit done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         tick();
         if (!m_full) done = 1;
      end
      checkOutput("commit_reached", {31'd0, done}, 32'd1);
   endtask

   task automatic waitPhase(input int ph);
      bit done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         tick();
         if (phaseOf(n) == ph) done = 1;
      end
      checkOutput("phase_reached", {31'd0, done}, 32'd1);
   endtask

   initial begin
      seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      vecs[0] = '{4'd1, 4'd7,  1'b0, 7'h78, 2'b01, 7'h79, 1'b1, 1'b0};
      vecs[1] = '{4'd0, 4'd5,  1'b1, 7'h12, 2'b01, 7'h40, 1'b0, 1'b0};
`ifdef LEADING_ZERO_BLANK_EN
      vecs[2] = '{4'd0, 4'd3,  1'b0, 7'h30, 2'b11, 7'h7F, 1'b1, 1'b0};
`else
      vecs[2] = '{4'd0, 4'd3,  1'b0, 7'h30, 2'b01, 7'h40, 1'b1, 1'b0};
`endif
      vecs[3] = '{4'd2, 4'hC,  1'b0, 7'h3F, 2'b01, 7'h24, 1'b1, 1'b1};
      vecs[4] = '{4'd9, 4'd8,  1'b1, 7'h00, 2'b01, 7'h10, 1'b0, 1'b0};
      vecs[5] = '{4'hA, 4'd0,  1'b0, 7'h40, 2'b01, 7'h3F, 1'b1, 1'b1};
      vecs[6] = '{4'd0, 4'd0,  1'b1, 7'h40, 2'b01, 7'h40, 1'b0, 1'b0};

      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);
      modelReset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      checkOutput("reset_seg",   {25'd0, seg_n}, 32'h7F);
      checkOutput("reset_an",    {30'd0, an_n}, 32'h3);
      checkOutput("reset_dp",    {31'd0, dp_n}, 32'd1);
      checkOutput("reset_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("reset_err",   {31'd0, err}, 32'd0);
      tick();
      rst_n = 1'b1;

      tick();
      checkOutput("first_gap_an", {30'd0, an_n}, 32'h3);
      tick();
      checkOutput("first_units_an",  {30'd0, an_n}, 32'h2);
      checkOutput("first_units_seg", {25'd0, seg_n}, 32'h40);
      waitPhase(2);
      checkOutput("first_tens_seg", {25'd0, seg_n}, 32'h40);
      checkOutput("first_tens_dp",  {31'd0, dp_n}, 32'd1);

      for (int k = 0; k < 7; k++) begin
         sendValue(vecs[k].tens, vecs[k].units, vecs[k].cout);
         checkOutput("ready_low_after_accept", {31'd0, in_ready}, 32'd0);
         waitCommit();
         checkOutput("vec_units_an",  {30'd0, an_n}, 32'h2);
         checkOutput("vec_units_seg", {25'd0, seg_n}, {25'd0, vecs[k].exp_useg});
         checkOutput("vec_err",       {31'd0, err}, {31'd0, vecs[k].exp_err});
         checkOutput("vec_ready_back", {31'd0, in_ready}, 32'd1);
         waitPhase(2);
         checkOutput("vec_tens_an",  {30'd0, an_n}, {30'd0, vecs[k].exp_tan});
         checkOutput("vec_tens_seg", {25'd0, seg_n}, {25'd0, vecs[k].exp_tseg});
         checkOutput("vec_tens_dp",  {31'd0, dp_n}, {31'd0, vecs[k].exp_dp});
      end

      // Back-to-back offers with in_valid held: second waits for the first commit.
      sendValue(4'd3, 4'd4, 1'b0);
      applyStimulus(1'b1, 4'd6, 4'd2, 1'b0);
      begin
         bit got = 0;
         for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (m_acc) got = 1;
         end
         checkOutput("second_accepted", {31'd0, got}, 32'd1);
         checkOutput("first_value_shown", {25'd0, seg_n}, 32'h19);
      end
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);
      waitPhase(2);
      #2 rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput("midreset_seg",   {25'd0, seg_n}, 32'h7F);
      checkOutput("midreset_an",    {30'd0, an_n}, 32'h3);
      checkOutput("midreset_ready", {31'd0, in_ready}, 32'd1);
      checkOutput("midreset_dp",    {31'd0, dp_n}, 32'd1);
      tick();
      rst_n = 1'b1;
      waitPhase(0);
      checkOutput("after_reset_units_seg", {25'd0, seg_n}, 32'h40);

      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         tick();
      end
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
